mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-requester memory bus arbiter placed between the pipeline's fetch stage, the memory stage and the single shared memory port. It latches one request at a time (instruction fetch or data load/store) into a request register and drives it downstream until the memory acknowledges. It then returns the read data to the granted requester as a one-cycle response pulse. It also absorbs requests abandoned mid-flight, such as a fetch cancelled by a branch flush.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request; held high until iresp_ok or until withdrawn
- ireq_addr  in  ADDR_W  fetch address
- iresp_ok  out  1  one-cycle fetch completion pulse
- iresp_data  out  DATA_W  fetch read data, valid with iresp_ok
- dreq_valid  in  1  data request; held high until dresp_ok or until withdrawn
- dreq_write  in  1  1 = store, 0 = load
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  access size, MemSizeType encoding (1 = 8b, 2 = 16b, 3 = 32b, 4 = 64b)
- dreq_strobe  in  DATA_W/8  byte enables for stores
- dreq_wdata  in  DATA_W  store data
- dresp_ok  out  1  one-cycle data completion pulse
- dresp_data  out  DATA_W  load data, valid with dresp_ok; don't-care for stores
- oreq_valid  out  1  downstream request valid
- oreq_write  out  1  downstream write
- oreq_addr  out  ADDR_W  downstream address
- oreq_size  out  3  downstream size
- oreq_strobe  out  DATA_W/8  downstream byte enables
- oreq_wdata  out  DATA_W  downstream write data
- oresp_ready  in  1  downstream completion; single-cycle pulse per transaction
- oresp_rdata  in  DATA_W  downstream read data, valid with oresp_ready

## Operation
- The FSM has four states: IDLE, REQ_I, REQ_D and RESP.
- **IDLE:**
  - If any valid is seen, latch the winner's fields into the request register and go to REQ_I or REQ_D.
  - A fetch is latched as a read: size = 4, strobe = 0, write = 0.
  - If no valid is seen, stay in IDLE.
- **Priority (default):** dreq has fixed priority over ireq when both are valid.
- **REQ_I / REQ_D:**
  - oreq_* are driven from the request register; oreq_valid = 1.
  - On oresp_ready, register oresp_rdata and go to RESP.
- **RESP:**
  - Pulse the owner's *_ok for one cycle, with registered data; the other *_ok stays 0.
  - Then go to IDLE unconditionally.
- **Withdrawal (flush):** if the owner's valid goes low at any point while in REQ_x, the downstream transaction still completes.
  - oreq_* are unchanged and never drop before oresp_ready.
  - A cancel flag is set, and the RESP cycle suppresses *_ok.
  - The cancel flag clears on entry to IDLE.
- Request fields are captured only at grant. Changes to requester inputs after grant have no effect.
- oresp_ready outside REQ_x is ignored.
- **Reset:** state = IDLE; every output is 0 (oreq_valid, oreq_* fields, iresp_ok, dresp_ok, *_data); cancel flag = 0; last-grant register = fetch.

## Timing
- **Grant:** valid sampled in IDLE at cycle 0; oreq_valid = 1 from cycle 1.
- **Completion:** oresp_ready at cycle k gives *_ok = 1 at cycle k+1, and state = IDLE at k+2.
- **Minimum latency:** valid at cycle 0, ready at cycle 1, ok at cycle 2.
- **Back-to-back:** a requester still asserting valid during its RESP cycle is not regranted from that sample. The next grant is sampled in IDLE.
- **Throughput:** at most one transaction per 3 cycles.
- **Asynchronous reset mid-transaction:** outputs clear immediately and the in-flight response is dropped. Downstream must be reset together.

## Configuration
- **ARB_ROUND_ROBIN_EN defined:** when both are valid in IDLE, grant the requester that did not win the previous grant, tracked by the last-grant register. When only one is valid, it wins.
- **ARB_ROUND_ROBIN_EN undefined:** fixed data-over-fetch priority. The last-grant register is not instantiated.

## Test plan
- **Single fetch:**
  - Stimulus: ireq_valid = 1, addr 0x8000_0000; oresp_ready at cycle 3, rdata 0x0000_0013_0000_0093.
  - Response: oreq_valid cycles 1–3 with addr 0x8000_0000, size 4, write 0; iresp_ok only at cycle 4 with that data; dresp_ok = 0 throughout.
- **Store:**
  - Stimulus: dreq write, addr 0x8000_1008, size 2, strobe 0x0C, wdata 0xBEEF_0000.
  - Response: oreq_* match exactly; dresp_ok pulses the cycle after ready.
- **Contention:**
  - Stimulus: ireq and dreq both valid at cycle 0; each acknowledged 1 cycle after its grant.
  - Response without macro: data first, dresp_ok at cycle 3, then fetch granted at cycle 5.
  - Response with macro: same for the first pair, since last grant at reset is fetch. A second simultaneous pair is then granted fetch first.
- **Flush:**
  - Stimulus: ireq_valid dropped at cycle 2 while in REQ_I; oresp_ready at cycle 4.
  - Response: oreq_* held through cycle 4; no iresp_ok at cycle 5; a pending dreq is granted at cycle 6.
- **Input change after grant:**
  - Stimulus: dreq_addr changes from 0x100 to 0x200 while in REQ_D.
  - Response: oreq_addr stays 0x100.
- **Reset mid-REQ_D:**
  - Stimulus: assert reset.
  - Response: oreq_valid and all *_ok fall within the same cycle; after release, the FSM is in IDLE and the next valid is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates an instruction-fetch requester and a data
// load/store requester onto one shared memory port, one transaction at a time.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When defined, simultaneous requests
// alternate via a last-grant register. When undefined, data always beats fetch.
//
// Handshake semantics (all interfaces):
//   - A requester raises *req_valid and holds it, with stable fields, until its
//     one-cycle *resp_ok pulse. Dropping it earlier withdraws the request: the
//     downstream access still completes but the *resp_ok pulse is suppressed.
//   - oreq_valid stays high with unchanged oreq_* fields until the single-cycle
//     oresp_ready pulse. oresp_ready is ignored whenever no request is outstanding.
//   - Request fields are captured only at grant. Later requester input changes
//     are ignored for the transaction in flight.
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    output logic                  iresp_ok,
    output logic [DATA_W-1:0]     iresp_data,
    input  logic                  dreq_valid,
    input  logic                  dreq_write,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [2:0]            dreq_size,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    input  logic [DATA_W-1:0]     dreq_wdata,
    output logic                  dresp_ok,
    output logic [DATA_W-1:0]     dresp_data,
    output logic                  oreq_valid,
    output logic                  oreq_write,
    output logic [ADDR_W-1:0]     oreq_addr,
    output logic [2:0]            oreq_size,
    output logic [DATA_W/8-1:0]   oreq_strobe,
    output logic [DATA_W-1:0]     oreq_wdata,
    input  logic                  oresp_ready,
    input  logic [DATA_W-1:0]     oresp_rdata,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ_I = 2'd1,
        ST_REQ_D = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Fetches always go downstream as a full-width read.
    localparam logic [2:0] FETCH_SIZE = 3'd4;

    state_t                state_q, state_d;
    logic                  owner_is_d_q, owner_is_d_d;
    logic                  cancel_q, cancel_d;
    logic                  req_write_q, req_write_d;
    logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
    logic [2:0]            req_size_q, req_size_d;
    logic [DATA_W/8-1:0]   req_strobe_q, req_strobe_d;
    logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  any_valid;
    logic                  grant_data;

    assign any_valid = ireq_valid | dreq_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // last_data_q = 1 when the most recent grant went to the data requester.
    logic last_data_q, last_data_d;

    // On contention, favour whichever requester did not win last time.
    assign grant_data = dreq_valid & (~ireq_valid | ~last_data_q);

    // Remember the winner of every grant taken in IDLE.
    always_comb begin
        last_data_d = last_data_q;
        if (state_q == ST_IDLE && any_valid) begin
            last_data_d = grant_data;
        end
    end

    // Last-grant register; resets to "fetch" so the first contention goes to data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    // Fixed priority: data wins whenever it is valid.
    assign grant_data = dreq_valid;
`endif

    // Next-state logic: grant in IDLE, wait for downstream completion, respond.
    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        cancel_d     = cancel_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_size_d   = req_size_q;
        req_strobe_d = req_strobe_q;
        req_wdata_d  = req_wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    owner_is_d_d = grant_data;
                    if (grant_data) begin
                        req_write_d  = dreq_write;
                        req_addr_d   = dreq_addr;
                        req_size_d   = dreq_size;
                        req_strobe_d = dreq_strobe;
                        req_wdata_d  = dreq_wdata;
                        state_d      = ST_REQ_D;
                    end else begin
                        req_write_d  = 1'b0;
                        req_addr_d   = ireq_addr;
                        req_size_d   = FETCH_SIZE;
                        req_strobe_d = '0;
                        req_wdata_d  = '0;
                        state_d      = ST_REQ_I;
                    end
                end
            end
            ST_REQ_I: begin
                if (!ireq_valid) begin
                    cancel_d = 1'b1;
                end
                if (oresp_ready) begin
                    rdata_d = oresp_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_REQ_D: begin
                if (!dreq_valid) begin
                    cancel_d = 1'b1;
                end
                if (oresp_ready) begin
                    rdata_d = oresp_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cancel_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request/response registers; reset clears every driven output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_is_d_q <= 1'b0;
            cancel_q     <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_size_q   <= '0;
            req_strobe_q <= '0;
            req_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            cancel_q     <= cancel_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_size_q   <= req_size_d;
            req_strobe_q <= req_strobe_d;
            req_wdata_q  <= req_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode straight from registers so an async reset clears them at once.
    always_comb begin
        oreq_valid  = (state_q == ST_REQ_I) || (state_q == ST_REQ_D);
        oreq_write  = req_write_q;
        oreq_addr   = req_addr_q;
        oreq_size   = req_size_q;
        oreq_strobe = req_strobe_q;
        oreq_wdata  = req_wdata_q;
        iresp_ok    = (state_q == ST_RESP) && !owner_is_d_q && !cancel_q;
        dresp_ok    = (state_q == ST_RESP) &&  owner_is_d_q && !cancel_q;
        iresp_data  = rdata_q;
        dresp_data  = rdata_q;
        dbg_state_o = state_q;
    end

endmodule
